cim_sbox_sequencer: RTL and testbench

CIM_SBOX_SEQUENCER -- requirements
Module: cim_sbox_sequencer

---
 rtl/cim_sbox_sequencer.sv | 153 +++++++++++++++
 tb/tb_cim_sbox_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cim_sbox_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cim_sbox_sequencer                                          |
// | Description : Sequences one AES round slice on a CIM macro: bit-serial    |
// |               AddRoundKey, then a 16-byte S-box lookup. Build option      |
// |               CIM_LAT2_EN selects a two-cycle CIM read latency.           |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module cim_sbox_sequencer (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         start,
    input  logic [127:0] state_in,
    input  logic [127:0] RIO,
    output logic [15:0]  IN,
    output logic         IN_EN,
    output logic [47:0]  DEMUX_ADD,
    output logic [95:0]  RWL_DEC_ADD,
    output logic         RD,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         done
);

`ifdef CIM_LAT2_EN
    localparam int unsigned C_LAT = 2;
`else
    localparam int unsigned C_LAT = 1;
`endif
    localparam logic [2:0]   C_LAST     = 3'(C_LAT - 1);
    localparam logic [127:0] C_LSB_MASK = {16{8'h01}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARK    = 3'd1,
        S_DRAIN  = 3'd2,
        S_LOOKUP = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [127:0]   data_q;
    logic [127:0]   ark_q;
    logic [127:0]   state_out_q;
    logic [C_LAT-1:0] vld_q;
    logic           w_sample;
    logic [15:0]    w_in;
    logic [47:0]    w_demux;
    logic [95:0]    w_rwl;

    assign w_sample  = vld_q[C_LAT-1];
    assign state_out = state_out_q;

    for (genvar j = 0; j < 16; j++) begin : g_byte
        assign w_in[j]                 = data_q[127-8*j];
        assign w_demux[47-3*j -: 3]    = {1'b0, ark_q[127-8*j -: 2]};
        assign w_rwl[95-6*j -: 6]      = ark_q[125-8*j -: 6];
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            vld_q       <= '0;
            data_q      <= '0;
            ark_q       <= '0;
            state_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_q[0] <= IN_EN;
            for (int i = 1; i < C_LAT; i++) vld_q[i] <= vld_q[i-1];

            // A whole-vector shift is safe: only 8 shifts occur, so each
            // byte's MSB never sees a bit borrowed from its neighbour.
            if (state_q == S_IDLE && start) begin
                data_q <= state_in;
                ark_q  <= '0;
            end else begin
                if (state_q == S_ARK)
                    data_q <= data_q << 1;
                if (w_sample)
                    ark_q <= ((ark_q << 1) & ~C_LSB_MASK) | (RIO & C_LSB_MASK);
            end

            if (state_q == S_WAIT && cnt_q == C_LAST)
                state_out_q <= RIO;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        IN          = '0;
        IN_EN       = 1'b0;
        DEMUX_ADD   = '0;
        RWL_DEC_ADD = '0;
        RD          = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_ARK;
                    cnt_d   = '0;
                end
            end
            S_ARK: begin
                IN    = w_in;
                IN_EN = 1'b1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == C_LAST) begin
                    state_d = S_LOOKUP;
                    cnt_d   = '0;
                end
            end
            S_LOOKUP: begin
                DEMUX_ADD   = w_demux;
                RWL_DEC_ADD = w_rwl;
                RD          = 1'b1;
                state_d     = S_WAIT;
                cnt_d       = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == C_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cim_sbox_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cim_sbox_sequencer                                       |
// | Description : Self-checking bench with a CIM responder and AES S-box      |
// |               reference model. Honours CIM_LAT2_EN.                       |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cim_sbox_sequencer;

`ifdef CIM_LAT2_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam int LAT = 10 + 2*L;

    localparam logic [0:255][7:0] SBOX = {
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic         CLK = 1'b0;
    logic         RSTn;
    logic         start;
    logic [127:0] state_in;
    logic [127:0] RIO;
    logic [15:0]  IN;
    logic         IN_EN;
    logic [47:0]  DEMUX_ADD;
    logic [95:0]  RWL_DEC_ADD;
    logic         RD;
    logic [127:0] state_out;
    logic         busy;
    logic         done;

    int           tests = 0;
    int           fails = 0;
    logic [127:0] key = '0;
    logic [127:0] prev_out = '0;
    logic [47:0]  last_demux;
    logic [95:0]  last_rwl;
    logic [2:0]   beat = '0;
    logic [127:0] resp;
    logic [127:0] rio_pipe [L];

    cim_sbox_sequencer dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .start       (start),
        .state_in    (state_in),
        .RIO         (RIO),
        .IN          (IN),
        .IN_EN       (IN_EN),
        .DEMUX_ADD   (DEMUX_ADD),
        .RWL_DEC_ADD (RWL_DEC_ADD),
        .RD          (RD),
        .state_out   (state_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    // CIM responder: XOR-with-key during ARK beats, S-box table on RD, delayed L cycles.
    always_comb begin
        resp = '0;
        for (int j = 0; j < 16; j++) begin
            if (RD)
                resp[127-8*j -: 8] = SBOX[{DEMUX_ADD[46-3*j -: 2], RWL_DEC_ADD[95-6*j -: 6]}];
            else
                resp[120-8*j] = IN[j] ^ (IN_EN & key[127 - 8*j - int'(beat)]);
        end
    end

    always_ff @(posedge CLK) begin
        beat        <= IN_EN ? beat + 3'd1 : 3'd0;
        rio_pipe[0] <= resp;
        for (int i = 1; i < L; i++) rio_pipe[i] <= rio_pipe[i-1];
    end
    assign RIO = rio_pipe[L-1];

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full round; edge 1 is the accept edge, edge LAT+1 is the IDLE cycle after done.
    task automatic run_round(input logic [127:0] st, input logic [127:0] kin, input bit hold);
        logic [127:0] exp_out;
        logic [47:0]  exp_demux;
        logic [95:0]  exp_rwl;
        logic [15:0]  e_in;
        logic [7:0]   a;
        for (int j = 0; j < 16; j++) begin
            a = st[127-8*j -: 8] ^ kin[127-8*j -: 8];
            exp_out[127-8*j -: 8]  = SBOX[a];
            exp_demux[47-3*j -: 3] = {1'b0, a[7:6]};
            exp_rwl[95-6*j -: 6]   = a[5:0];
        end
        @(negedge CLK);
        state_in = st;
        key      = kin;
        start    = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            @(posedge CLK);
            #1;
            if (e == 1 && !hold) start = 1'b0;
            e_in = '0;
            if (e >= 1 && e <= 8)
                for (int j = 0; j < 16; j++) e_in[j] = st[127 - 8*j - (e-1)];
            chk("ctl", {IN_EN, IN, RD, done, busy},
                {(e <= 8), e_in, (e == 9 + L), (e == LAT), (e <= LAT)});
            if (e == 9 + L) begin
                last_demux = DEMUX_ADD;
                last_rwl   = RWL_DEC_ADD;
                chk("lookup_addr", {DEMUX_ADD, RWL_DEC_ADD}, {exp_demux, exp_rwl});
            end else begin
                chk("addr_idle", {DEMUX_ADD, RWL_DEC_ADD}, '0);
            end
            chk("state_out", state_out, (e >= LAT) ? exp_out : prev_out);
        end
        prev_out = exp_out;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTn     = 1'b0;
        start    = 1'b1;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outputs", {IN, IN_EN, RD, busy, done, state_out},
            '0);
        chk("reset_addr", {DEMUX_ADD, RWL_DEC_ADD}, '0);
        @(negedge CLK);
        start = 1'b0;
        RSTn  = 1'b1;
        @(posedge CLK);
        #1;
        chk("idle_after_release", {busy, done, IN_EN, RD}, '0);

        // Identity responder on the reference vector
        run_round(128'h00112233445566778899aabbccddeeff, '0, 1'b0);
        chk("id_state_out", state_out, 128'h638293c31bfc33f5c4eeacea4bc12816);
        chk("id_byte1_addr", {last_demux[44 -: 3], last_rwl[89 -: 6]}, {3'd0, 6'h11});

        // XOR-key responder
        run_round(128'h00112233445566778899aabbccddeeff,
                  128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        chk("xor_byte15_addr", {last_demux[2:0], last_rwl[5:0]}, {3'd3, 6'h30});

        // Start held high: next round is taken right after the single IDLE cycle
        run_round({$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        run_round({$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 1'b0);

        // Reset during ARK beat k=4
        @(negedge CLK);
        state_in = {$urandom, $urandom, $urandom, $urandom};
        start    = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("ark_k4_active", {IN_EN, busy}, 2'b11);
        @(negedge CLK);
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        chk("mid_reset", {IN_EN, busy, done, RD, state_out}, '0);
        @(negedge CLK);
        RSTn = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge CLK);
            #1;
            chk("abandoned_round", {busy, done, IN_EN, RD, state_out}, '0);
        end
        prev_out = '0;

        for (int r = 0; r < 4; r++)
            run_round({$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom}, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
